// File: rtl/proc_mem_pkg.sv
// Shared types and constants for the processor data-memory responder.
package proc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [15:0] TIMEOUT_DATA    = 16'hDEAD;
  localparam int          DEF_ADDR_W      = 16;
  localparam int          DEF_TIMEOUT_CYC = 255;

endpackage

// File: rtl/proc_mem_timeout_ctr.sv
// Backend wait counter: counts enabled cycles since the last clear and flags
// the cycle on which the wait would reach LIMIT.
module proc_mem_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (clr || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // The current waiting cycle is number cnt+1, so it fires on the LIMIT-th one.
  assign expired = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/proc_mem_responder.sv
// Serialises processor data-memory requests onto a req/ack backend port and
// stalls the core meanwhile. Optional backend timeout: PROC_MEM_TIMEOUT_EN.
module proc_mem_responder
  import proc_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              pulse_en,
  input  logic              mem_read_enable,
  input  logic              mem_write_enable,
  input  logic [31:0]       mem_write_addr,
  input  logic [15:0]       mem_write_data,
  output logic [15:0]       mem_read_data,
  output logic              stall,
  output logic              bk_req,
  output logic              bk_we,
  output logic [ADDR_W-1:0] bk_addr,
  output logic [15:0]       bk_wdata,
  input  logic              bk_ack,
  input  logic [15:0]       bk_rdata,
  output logic              bus_err
);

  state_t state, state_nxt;
  logic   served;
  logic   new_req;
  logic   in_range;
  logic   timeout_hit;

  // served blocks a request the core is still holding after it completed.
  assign new_req  = (mem_read_enable | mem_write_enable) & ~served;
  assign in_range = (mem_write_addr >> ADDR_W) == 32'd0;

`ifdef PROC_MEM_TIMEOUT_EN
  proc_mem_timeout_ctr #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .clr     (clr),
    .clear   (state != ISSUE),
    .en      ((state == ISSUE) && !bk_ack),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (new_req) begin
          stall     = 1'b1;
          state_nxt = in_range ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        stall = 1'b1;
        if (bk_ack || timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state         <= IDLE;
      served        <= 1'b0;
      mem_read_data <= '0;
      bk_req        <= 1'b0;
      bk_we         <= 1'b0;
      bk_addr       <= '0;
      bk_wdata      <= '0;
      bus_err       <= 1'b0;
    end else begin
      state <= state_nxt;

      // A core step in DONE consumes the access, so the clear takes priority.
      if (pulse_en && !stall) begin
        served <= 1'b0;
      end else if (state == DONE) begin
        served <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (new_req) begin
            bk_we    <= mem_write_enable;
            bk_addr  <= mem_write_addr[ADDR_W-1:0];
            bk_wdata <= mem_write_data;
            if (in_range) begin
              bk_req <= 1'b1;
            end else begin
              bus_err <= 1'b1;
              if (!mem_write_enable) mem_read_data <= '0;
            end
          end
        end
        ISSUE: begin
          if (bk_ack) begin
            bk_req <= 1'b0;
            if (!bk_we) mem_read_data <= bk_rdata;
          end else if (timeout_hit) begin
            bk_req  <= 1'b0;
            bus_err <= 1'b1;
            if (!bk_we) mem_read_data <= TIMEOUT_DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_mem_responder.sv
// Scoreboard bench for proc_mem_responder: stimulus queues expected backend
// requests and completions, a negedge monitor pops and compares them.
module tb_proc_mem_responder;

  logic        clk = 1'b0;
  logic        clr;
  logic        pulse_en;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_write_addr;
  logic [15:0] mem_write_data;
  logic [15:0] mem_read_data;
  logic        stall;
  logic        bk_req;
  logic        bk_we;
  logic [15:0] bk_addr;
  logic [15:0] bk_wdata;
  logic        bk_ack;
  logic [15:0] bk_rdata;
  logic        bus_err;

  proc_mem_responder #(
    .ADDR_W      (16),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk              (clk),
    .clr              (clr),
    .pulse_en         (pulse_en),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_write_addr   (mem_write_addr),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data),
    .stall            (stall),
    .bk_req           (bk_req),
    .bk_we            (bk_we),
    .bk_addr          (bk_addr),
    .bk_wdata         (bk_wdata),
    .bk_ack           (bk_ack),
    .bk_rdata         (bk_rdata),
    .bus_err          (bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } bk_exp_t;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          cyc;
  } done_exp_t;

  bk_exp_t   bk_q[$];
  done_exp_t done_q[$];

  int checks = 0;
  int fails  = 0;
  int n_req  = 0;
  int n_done = 0;

  // Backend model controls
  bit          ack_en    = 1'b1;
  int          ack_wait  = 0;
  logic [15:0] resp_data = 16'h0;
  bit          stray_req = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Backend model: acks after ack_wait idle bk_req cycles; drives at posedge+1.
  initial begin
    int waited;
    waited   = 0;
    bk_ack   = 1'b0;
    bk_rdata = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      bk_ack = 1'b0;
      if (bk_req && ack_en) begin
        if (waited == ack_wait) begin
          bk_ack   = 1'b1;
          bk_rdata = resp_data;
          waited   = 0;
        end else begin
          waited++;
        end
      end else if (!bk_req) begin
        waited = 0;
      end
      if (stray_req) begin
        bk_ack   = 1'b1;
        bk_rdata = 16'hFFFF;
      end
    end
  end

  // Monitor: compares backend requests and completed accesses.
  initial begin
    logic prev_req;
    int   stall_cnt;
    bk_exp_t   be;
    done_exp_t de;
    prev_req  = 1'b0;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (clr) begin
        stall_cnt = 0;
      end else begin
        if (bk_req && !prev_req) begin
          n_req++;
          if (bk_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL bk_req: unexpected request addr 0x%0h we %0b", bk_addr, bk_we);
          end else begin
            be = bk_q.pop_front();
            check("bk_addr", 32'(bk_addr), 32'(be.addr));
            check("bk_we", 32'(bk_we), 32'(be.we));
            if (be.we) check("bk_wdata", 32'(bk_wdata), 32'(be.wdata));
          end
        end
        if (stall) begin
          stall_cnt++;
        end else if (stall_cnt > 0) begin
          n_done++;
          if (done_q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL completion: unexpected, stall cycles %0d", stall_cnt);
          end else begin
            de = done_q.pop_front();
            check("mem_read_data", 32'(mem_read_data), 32'(de.rdata));
            check("bus_err", 32'(bus_err), 32'(de.err));
            check("stall_cycles", 32'(stall_cnt), 32'(de.cyc));
          end
          stall_cnt = 0;
        end
      end
      prev_req = bk_req;
    end
  end

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (n_done < target && k < 200) begin
      tick();
      k++;
    end
    checks++;
    if (n_done < target) begin
      fails++;
      $display("FAIL wait_done: completions %0d expected %0d", n_done, target);
    end
  endtask

  task automatic release_core();
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    pulse_en         = 1'b1;
    tick();
    pulse_en = 1'b0;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [15:0] wd, input int wait_c, input logic [15:0] rdat,
                        input logic [15:0] exp_rd, input logic exp_err, input int exp_cyc,
                        input bit hold);
    bk_exp_t   be;
    done_exp_t de;
    int        target;
    if ((addr >> 16) == 32'd0) begin
      be.we    = wr;
      be.addr  = addr[15:0];
      be.wdata = wd;
      bk_q.push_back(be);
    end
    de.rdata = exp_rd;
    de.err   = exp_err;
    de.cyc   = exp_cyc;
    done_q.push_back(de);
    target           = n_done + 1;
    ack_wait         = wait_c;
    resp_data        = rdat;
    mem_write_addr   = addr;
    mem_write_data   = wd;
    mem_read_enable  = rd;
    mem_write_enable = wr;
    wait_done(target);
    if (!hold) release_core();
  endtask

  initial begin
    bk_exp_t   be;
    done_exp_t de;
    int        req_base;
    int        k;
    clr              = 1'b1;
    pulse_en         = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_write_addr   = 32'h0;
    mem_write_data   = 16'h0;
    repeat (3) tick();

    check("rst_stall", 32'(stall), 32'd0);
    check("rst_bk_req", 32'(bk_req), 32'd0);
    check("rst_bk_we", 32'(bk_we), 32'd0);
    check("rst_bk_addr", 32'(bk_addr), 32'd0);
    check("rst_bk_wdata", 32'(bk_wdata), 32'd0);
    check("rst_mem_read_data", 32'(mem_read_data), 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    clr = 1'b0;
    tick();

    // rd wr addr wdata wait rdata exp_rd err cyc hold
    access(1'b1, 1'b0, 32'h0000_0010, 16'h0000, 0, 16'h1234, 16'h1234, 1'b0, 2, 1'b0);
    access(1'b0, 1'b1, 32'h0000_0020, 16'hBEEF, 3, 16'h9999, 16'h1234, 1'b0, 5, 1'b0);

    // Held request: no re-issue until the core steps
    req_base = n_req;
    access(1'b1, 1'b0, 32'h0000_0030, 16'h0000, 0, 16'h5555, 16'h5555, 1'b0, 2, 1'b1);
    repeat (10) tick();
    check("held_no_reissue", 32'(n_req - req_base), 32'd1);
    check("held_stall_low", 32'(stall), 32'd0);
    be.we = 1'b0; be.addr = 16'h0030; be.wdata = 16'h0000;
    bk_q.push_back(be);
    de.rdata = 16'h6666; de.err = 1'b0; de.cyc = 2;
    done_q.push_back(de);
    resp_data = 16'h6666;
    k         = n_done + 1;
    pulse_en  = 1'b1;
    tick();
    pulse_en = 1'b0;
    wait_done(k);
    release_core();
    check("held_reissue", 32'(n_req - req_base), 32'd2);

    // Out of range, sticky error, dropped out-of-range write
    req_base = n_req;
    access(1'b1, 1'b0, 32'h0001_0000, 16'h0000, 0, 16'h0000, 16'h0000, 1'b1, 1, 1'b0);
    check("oor_no_bk_req", 32'(n_req - req_base), 32'd0);
    access(1'b1, 1'b0, 32'h0000_0060, 16'h0000, 1, 16'h7777, 16'h7777, 1'b1, 3, 1'b0);
    req_base = n_req;
    access(1'b0, 1'b1, 32'h1234_0000, 16'hCAFE, 0, 16'h0000, 16'h7777, 1'b1, 1, 1'b0);
    check("oor_wr_no_bk_req", 32'(n_req - req_base), 32'd0);

    // Both enables high -> write; then reset in the middle of ISSUE
    ack_en = 1'b0;
    be.we = 1'b1; be.addr = 16'h0040; be.wdata = 16'hA5A5;
    bk_q.push_back(be);
    req_base         = n_req;
    mem_write_addr   = 32'h0000_0040;
    mem_write_data   = 16'hA5A5;
    mem_read_enable  = 1'b1;
    mem_write_enable = 1'b1;
    k = 0;
    while (n_req == req_base && k < 50) begin
      tick();
      k++;
    end
    check("both_en_issued", 32'(n_req - req_base), 32'd1);
    tick();
    tick();
    clr              = 1'b1;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    tick();
    clr = 1'b0;
    check("clr_bk_req", 32'(bk_req), 32'd0);
    check("clr_stall", 32'(stall), 32'd0);
    check("clr_bus_err", 32'(bus_err), 32'd0);
    check("clr_mem_read_data", 32'(mem_read_data), 32'd0);
    stray_req = 1'b1;
    tick();
    stray_req = 1'b0;
    repeat (3) tick();
    check("stray_ack_bk_req", 32'(bk_req), 32'd0);
    check("stray_ack_no_req", 32'(n_req - req_base), 32'd1);
    ack_en = 1'b1;
    access(1'b1, 1'b0, 32'h0000_0050, 16'h0000, 0, 16'h0F0F, 16'h0F0F, 1'b0, 2, 1'b0);

`ifdef PROC_MEM_TIMEOUT_EN
    ack_en = 1'b0;
    access(1'b1, 1'b0, 32'h0000_0070, 16'h0000, 0, 16'h0000, 16'hDEAD, 1'b1, 5, 1'b0);
    check("timeout_bk_req", 32'(bk_req), 32'd0);
    ack_en = 1'b1;
`endif

    repeat (3) tick();
    checks++;
    if (bk_q.size() != 0 || done_q.size() != 0) begin
      fails++;
      $display("FAIL queues_empty: bk %0d done %0d left, expected 0", bk_q.size(), done_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
